// File: rtl/i2c_txn_arbiter.sv
`default_nettype none
// ============================================================================
// i2c_txn_arbiter : round-robin arbiter + transaction sequencer for one I2C master
// Revision 1.0
// ============================================================================
module i2c_txn_arbiter #(
  parameter int N_REQ      = 2,
  parameter int START_TO   = 100000,
  parameter int XFER_TO    = 4000000,
  parameter int GAP_CYCLES = 5000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [7*N_REQ-1:0] req_addr_i,
  input  logic [8*N_REQ-1:0] req_data_i,
  input  logic [N_REQ-1:0]   req_rw_i,
  output logic [N_REQ-1:0]   gnt_o,
  output logic [N_REQ-1:0]   done_o,
  output logic               err_o,
  output logic [7:0]         rdata_o,
  output logic               m_start_o,
  output logic [6:0]         m_addr_o,
  output logic [7:0]         m_data_o,
  output logic               m_rw_o,
  input  logic               m_busy_i,
  input  logic               m_nack_i,
  input  logic [7:0]         m_rdata_i
);

  localparam int c_TMAX = (START_TO > XFER_TO)
                        ? ((START_TO > GAP_CYCLES) ? START_TO : GAP_CYCLES)
                        : ((XFER_TO  > GAP_CYCLES) ? XFER_TO  : GAP_CYCLES);
  localparam int c_TW   = $clog2(c_TMAX + 1);
  localparam int c_IW   = $clog2(N_REQ);
  localparam logic [c_TW-1:0] c_START_LIM = c_TW'(START_TO);
  localparam logic [c_TW-1:0] c_XFER_LIM  = c_TW'(XFER_TO);
  localparam logic [c_TW-1:0] c_GAP_LAST  = c_TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_XFER  = 3'd2,
    S_DONE  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t           state_q;
  logic [c_TW-1:0]  timer_q;
  logic [c_TW-1:0]  timer_d;
  logic [c_IW-1:0]  last_q;
  logic [c_IW-1:0]  gidx_q;
  logic [N_REQ-1:0] gnt_q;
  logic [N_REQ-1:0] done_q;
  logic             err_q;
  logic [7:0]       rdata_q;
  logic             m_start_q;
  logic [6:0]       m_addr_q;
  logic [7:0]       m_data_q;
  logic             m_rw_q;

  logic             win_vld;
  logic [c_IW-1:0]  win_idx;
  logic [c_IW-1:0]  cidx;
  logic [N_REQ-1:0] win_oh;
  logic [6:0]       win_addr;
  logic [7:0]       win_data;
  logic             win_rw;

  // Shared state timer saturates at all-ones, which is never below any limit.
  always_comb begin
    timer_d = (&timer_q) ? timer_q : timer_q + 1'b1;
  end

  // Search starts one past the last served requester and wraps around.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    cidx     = '0;
    win_oh   = '0;
    win_addr = '0;
    win_data = '0;
    win_rw   = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cidx = c_IW'((int'(last_q) + k) % N_REQ);
      if (!win_vld && req_i[cidx]) begin
        win_vld = 1'b1;
        win_idx = cidx;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (win_vld && (win_idx == c_IW'(i))) begin
        win_oh[i] = 1'b1;
        win_addr  = req_addr_i[7*i +: 7];
        win_data  = req_data_i[8*i +: 8];
        win_rw    = req_rw_i[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      last_q    <= c_IW'(N_REQ - 1);
      gidx_q    <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      m_start_q <= 1'b0;
      m_addr_q  <= '0;
      m_data_q  <= '0;
      m_rw_q    <= 1'b0;
    end else begin
      timer_q <= timer_d;
      case (state_q)
        S_IDLE: begin
          if (win_vld) begin
            gnt_q     <= win_oh;
            gidx_q    <= win_idx;
            m_addr_q  <= win_addr;
            m_data_q  <= win_data;
            m_rw_q    <= win_rw;
            m_start_q <= 1'b1;
            timer_q   <= '0;
            state_q   <= S_START;
          end
        end
        S_START: begin
          if (m_busy_i) begin
            m_start_q <= 1'b0;
            timer_q   <= '0;
            state_q   <= S_XFER;
          end else if (timer_q >= c_START_LIM) begin
            m_start_q <= 1'b0;
            err_q     <= 1'b1;
            done_q    <= gnt_q;
            timer_q   <= '0;
            state_q   <= S_DONE;
          end
        end
        S_XFER: begin
          // A busy fall wins over a simultaneous timeout.
          if (!m_busy_i) begin
            rdata_q <= m_rdata_i;
            err_q   <= m_nack_i;
            done_q  <= gnt_q;
            timer_q <= '0;
            state_q <= S_DONE;
          end else if (timer_q >= c_XFER_LIM) begin
            err_q   <= 1'b1;
            done_q  <= gnt_q;
            timer_q <= '0;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= '0;
          err_q   <= 1'b0;
          gnt_q   <= '0;
          last_q  <= gidx_q;
          timer_q <= '0;
          state_q <= S_GAP;
        end
        S_GAP: begin
          if (timer_q >= c_GAP_LAST) begin
            timer_q <= '0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          timer_q <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt_o     = gnt_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign rdata_o   = rdata_q;
  assign m_start_o = m_start_q;
  assign m_addr_o  = m_addr_q;
  assign m_data_o  = m_data_q;
  assign m_rw_o    = m_rw_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_txn_arbiter.sv
`default_nettype none
// ============================================================================
// tb_i2c_txn_arbiter : directed bench with a small behavioural I2C master model
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_i2c_txn_arbiter;

  localparam int N_REQ      = 2;
  localparam int START_TO   = 50;
  localparam int XFER_TO    = 300;
  localparam int GAP_CYCLES = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [13:0] req_addr;
  logic [15:0] req_data;
  logic [1:0]  req_rw;
  logic [1:0]  gnt;
  logic [1:0]  done;
  logic        err;
  logic [7:0]  rdata;
  logic        m_start;
  logic [6:0]  m_addr;
  logic [7:0]  m_data;
  logic        m_rw;
  logic        m_busy;
  logic        m_nack;
  logic [7:0]  m_rdata;

  always #5 clk = ~clk;

  i2c_txn_arbiter #(
    .N_REQ(N_REQ), .START_TO(START_TO), .XFER_TO(XFER_TO), .GAP_CYCLES(GAP_CYCLES)
  ) u_dut (
    .clk(clk), .reset(reset),
    .req_i(req), .req_addr_i(req_addr), .req_data_i(req_data), .req_rw_i(req_rw),
    .gnt_o(gnt), .done_o(done), .err_o(err), .rdata_o(rdata),
    .m_start_o(m_start), .m_addr_o(m_addr), .m_data_o(m_data), .m_rw_o(m_rw),
    .m_busy_i(m_busy), .m_nack_i(m_nack), .m_rdata_i(m_rdata)
  );

  // Master model: busy rises cfg_dly cycles after start is seen, holds cfg_hold cycles.
  int   cfg_dly;
  int   cfg_hold;
  logic cfg_norise;
  logic cfg_stuck;
  logic mm_active;
  int   mm_cnt;

  always @(posedge clk) begin
    if (reset) begin
      m_busy    <= 1'b0;
      mm_active <= 1'b0;
      mm_cnt    <= 0;
    end else if (cfg_stuck) begin
      m_busy    <= 1'b1;
      mm_active <= 1'b0;
      mm_cnt    <= 0;
    end else if (!mm_active) begin
      m_busy <= 1'b0;
      if (m_start && !cfg_norise) begin
        if (mm_cnt == cfg_dly - 1) begin
          m_busy    <= 1'b1;
          mm_active <= 1'b1;
          mm_cnt    <= 0;
        end else begin
          mm_cnt <= mm_cnt + 1;
        end
      end else begin
        mm_cnt <= 0;
      end
    end else begin
      if (mm_cnt == cfg_hold - 1) begin
        m_busy    <= 1'b0;
        mm_active <= 1'b0;
        mm_cnt    <= 0;
      end else begin
        mm_cnt <= mm_cnt + 1;
      end
    end
  end

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input int limit, output int steps);
    steps = 0;
    while (gnt == 2'b00 && steps < limit) begin
      step();
      steps++;
    end
    check_vec("gnt_seen", {31'b0, gnt != 2'b00}, 32'd1);
  endtask

  task automatic wait_done(input int limit, output int steps);
    steps = 0;
    while (done == 2'b00 && steps < limit) begin
      step();
      steps++;
    end
    check_vec("done_seen", {31'b0, done != 2'b00}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   st;
    int   slen;
    logic seen;
    reset = 1'b1; req = '0; req_addr = '0; req_data = '0; req_rw = '0;
    m_nack = 1'b0; m_rdata = '0;
    cfg_dly = 3; cfg_hold = 200; cfg_norise = 1'b0; cfg_stuck = 1'b0;
    repeat (3) step();
    check_vec("rst_gnt_done", {gnt, done}, 0);
    check_vec("rst_err_rdata", {err, rdata}, 0);
    check_vec("rst_master", {m_start, m_addr, m_data, m_rw}, 0);
    reset = 1'b0;
    step();

    // Single write from requester 0
    req_addr = 14'h0002; req_data = 16'h002F; req_rw = 2'b00; req = 2'b01;
    step();
    check_vec("wr_gnt", gnt, 2'b01);
    check_vec("wr_mstart", m_start, 1);
    check_vec("wr_maddr", m_addr, 7'h02);
    check_vec("wr_mdata", m_data, 8'h2F);
    check_vec("wr_mrw", m_rw, 0);
    req = 2'b00; req_addr = 14'h3FFF; req_data = 16'hFFFF; req_rw = 2'b11;
    slen = 1;
    while (m_start && slen < 20) begin
      step();
      if (m_start) slen++;
    end
    check_vec("wr_start_len", slen, 4);
    check_vec("wr_maddr_hold", m_addr, 7'h02);
    wait_done(400, st);
    check_vec("wr_latency", slen + st, 204);
    check_vec("wr_done", done, 2'b01);
    check_vec("wr_err", err, 0);
    check_vec("wr_gnt_in_done", gnt, 2'b01);
    check_vec("wr_mdata_hold", m_data, 8'h2F);
    step();
    check_vec("wr_done_pulse", {gnt, done}, 0);

    // Read from requester 1
    m_rdata = 8'hA5; cfg_dly = 2; cfg_hold = 20;
    req_addr = {7'h50, 7'h00}; req_rw = 2'b10; req = 2'b10;
    wait_gnt(40, st);
    check_vec("rd_gnt", gnt, 2'b10);
    check_vec("rd_maddr", m_addr, 7'h50);
    check_vec("rd_mrw", m_rw, 1);
    req = 2'b00;
    wait_done(100, st);
    check_vec("rd_done", done, 2'b10);
    check_vec("rd_err", err, 0);
    check_vec("rd_rdata", rdata, 8'hA5);

    // NACK from requester 0, also measures the bus-free gap
    req_addr = {7'h00, 7'h33}; req_rw = 2'b00; req = 2'b01;
    m_nack = 1'b1; m_rdata = 8'h3C; cfg_dly = 1; cfg_hold = 5;
    step();
    wait_gnt(40, st);
    check_vec("gap_len", st + 1, 12);
    check_vec("nack_gnt", gnt, 2'b01);
    req = 2'b00;
    wait_done(100, st);
    check_vec("nack_done", done, 2'b01);
    check_vec("nack_err", err, 1);
    m_nack = 1'b0;

    // START timeout: busy never rises
    step();
    cfg_norise = 1'b1; req = 2'b10;
    wait_gnt(40, st);
    req = 2'b00;
    wait_done(200, st);
    check_vec("sto_latency", st, 51);
    check_vec("sto_done", done, 2'b10);
    check_vec("sto_err", err, 1);
    check_vec("sto_mstart", m_start, 0);
    cfg_norise = 1'b0;

    // XFER timeout: busy stuck high, already high while idle
    step();
    cfg_stuck = 1'b1; req = 2'b01;
    wait_gnt(40, st);
    req = 2'b00;
    wait_done(400, st);
    check_vec("xto_latency", st, 302);
    check_vec("xto_done", done, 2'b01);
    check_vec("xto_err", err, 1);
    cfg_stuck = 1'b0;

    // Reset in the middle of a transfer
    step();
    cfg_dly = 3; cfg_hold = 200;
    req_addr = {7'h00, 7'h77}; req = 2'b01;
    wait_gnt(40, st);
    req = 2'b00;
    repeat (10) step();
    check_vec("mid_in_xfer", {gnt, m_start}, 3'b010);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_vec("mid_rst_gnt_done", {gnt, done}, 0);
    check_vec("mid_rst_err_rdata", {err, rdata}, 0);
    check_vec("mid_rst_master", {m_start, m_addr, m_data, m_rw}, 0);
    seen = 1'b0;
    repeat (250) begin
      step();
      if (done != 2'b00) seen = 1'b1;
    end
    check_vec("mid_no_done", seen, 0);

    // Round robin with both requesting continuously
    req_addr = {7'h22, 7'h11}; req_rw = 2'b00; cfg_dly = 1; cfg_hold = 3;
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(40, st);
      check_vec($sformatf("rr%0d_gnt", i), gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
      check_vec($sformatf("rr%0d_maddr", i), m_addr, (i % 2 == 0) ? 7'h11 : 7'h22);
      wait_done(60, st);
      check_vec($sformatf("rr%0d_done", i), done, (i % 2 == 0) ? 2'b01 : 2'b10);
      check_vec($sformatf("rr%0d_err", i), err, 0);
      step();
    end
    req = 2'b00;
    repeat (5) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
